// File: rtl/mem_bus_pkg.sv
// Shared widths, bank IDs and read-path FSM states for the request/ack memory bus.
package mem_bus_pkg;

  localparam int unsigned BANK_W     = 4;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned BUS_ADDR_W = 24;

  localparam logic [BANK_W-1:0] BANK_0 = 4'd0;
  localparam logic [BANK_W-1:0] BANK_1 = 4'd1;
  localparam logic [BANK_W-1:0] BANK_2 = 4'd2;
  localparam logic [BANK_W-1:0] BANK_3 = 4'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD_DRAIN,
    S_RD_REQ,
    S_RD_WAIT
  } rd_state_e;

endpackage

// File: rtl/mem_bus_wbuf.sv
// Posted-write FIFO; the head entry is read straight out of the storage registers.
module mem_bus_wbuf #(
  parameter int unsigned WIDTH = 56,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [WIDTH-1:0]           head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign count = count_q;
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/mem_bus_responder.sv
// Bus responder: posts writes through a small buffer, serves one read at a time after
// the buffer drains, and forwards everything to a valid/ready memory controller port.
module mem_bus_responder
  import mem_bus_pkg::*;
#(
  parameter logic [BANK_W-1:0] BANK       = BANK_1,
  parameter int unsigned       ADDR_W     = 24,
  parameter int unsigned       WBUF_DEPTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_request,
  input  logic                  i_write,
  input  logic [BANK_W-1:0]     i_bank,
  input  logic [BUS_ADDR_W-1:0] i_address,
  input  logic [DATA_W-1:0]     i_data,
  output logic                  o_busy,
  output logic                  o_ack,
  output logic [DATA_W-1:0]     o_data,
  output logic                  o_mem_req,
  output logic                  o_mem_write,
  output logic [ADDR_W-1:0]     o_mem_address,
  output logic [DATA_W-1:0]     o_mem_wdata,
  input  logic                  i_mem_ready,
  input  logic                  i_mem_rvalid,
  input  logic [DATA_W-1:0]     i_mem_rdata
);

  localparam int unsigned CNT_W = $clog2(WBUF_DEPTH + 1);
  localparam int unsigned ENT_W = ADDR_W + DATA_W;

  logic             accept, rd_accept, push, pop, busy_next;
  logic             wbuf_full, wbuf_empty;
  logic [CNT_W-1:0] wbuf_count, count_next;
  logic [ENT_W-1:0] wbuf_head;
  rd_state_e        state, state_next;
  logic [ADDR_W-1:0] rd_addr;
  logic             rd_outstanding;

  assign accept    = i_request && !o_busy && (i_bank == BANK);
  assign rd_accept = accept && !i_write;
  assign push      = accept && i_write && !wbuf_full;
  assign pop       = o_mem_req && i_mem_ready && o_mem_write;
  assign count_next = wbuf_count + CNT_W'(push) - CNT_W'(pop);

  mem_bus_wbuf #(
    .WIDTH (ENT_W),
    .DEPTH (WBUF_DEPTH)
  ) u_wbuf (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .push      (push),
    .push_data ({i_address[ADDR_W-1:0], i_data}),
    .pop       (pop),
    .full      (wbuf_full),
    .empty     (wbuf_empty),
    .count     (wbuf_count),
    .head      (wbuf_head)
  );

  // A read skips the drain state when the buffer will already be empty after this edge.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:     if (rd_accept) state_next = (count_next == '0) ? S_RD_REQ : S_RD_DRAIN;
      S_RD_DRAIN: if (count_next == '0) state_next = S_RD_REQ;
      S_RD_REQ:   if (i_mem_ready) state_next = S_RD_WAIT;
      S_RD_WAIT:  if (rd_outstanding && i_mem_rvalid) state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  assign busy_next = (count_next == CNT_W'(WBUF_DEPTH)) || (state_next != S_IDLE) || rd_accept;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state          <= S_IDLE;
      o_busy         <= 1'b0;
      o_ack          <= 1'b0;
      o_data         <= '0;
      rd_addr        <= '0;
      rd_outstanding <= 1'b0;
    end else begin
      state  <= state_next;
      o_busy <= busy_next;
      o_ack  <= 1'b0;
      if (state == S_IDLE && rd_accept) rd_addr <= i_address[ADDR_W-1:0];
      if (state == S_RD_REQ && i_mem_ready) rd_outstanding <= 1'b1;
      if (state == S_RD_WAIT && rd_outstanding && i_mem_rvalid) begin
        o_ack          <= 1'b1;
        o_data         <= i_mem_rdata;
        rd_outstanding <= 1'b0;
      end
    end
  end

  // Idle fields are forced to zero so nothing from unreset storage leaks out.
  always_comb begin
    o_mem_req     = 1'b0;
    o_mem_write   = 1'b0;
    o_mem_address = '0;
    o_mem_wdata   = '0;
    if (state == S_RD_REQ) begin
      o_mem_req     = 1'b1;
      o_mem_address = rd_addr;
    end else if (!wbuf_empty) begin
      o_mem_req     = 1'b1;
      o_mem_write   = 1'b1;
      o_mem_address = wbuf_head[ENT_W-1:DATA_W];
      o_mem_wdata   = wbuf_head[DATA_W-1:0];
    end
  end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Bench for mem_bus_responder: fixed vector table, directed corner sequences, and random
// initiator traffic scored against an address->data memory model.
module tb_mem_bus_responder;

  localparam logic [3:0] BANK = 4'd1;

  logic        i_clk, i_reset, i_request, i_write;
  logic [3:0]  i_bank;
  logic [23:0] i_address;
  logic [31:0] i_data;
  logic        o_busy, o_ack, o_mem_req, o_mem_write;
  logic [31:0] o_data, o_mem_wdata;
  logic [23:0] o_mem_address;
  logic        i_mem_ready, i_mem_rvalid;
  logic [31:0] i_mem_rdata;

  mem_bus_responder #(
    .BANK       (BANK),
    .ADDR_W     (24),
    .WBUF_DEPTH (4)
  ) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_request     (i_request),
    .i_write       (i_write),
    .i_bank        (i_bank),
    .i_address     (i_address),
    .i_data        (i_data),
    .o_busy        (o_busy),
    .o_ack         (o_ack),
    .o_data        (o_data),
    .o_mem_req     (o_mem_req),
    .o_mem_write   (o_mem_write),
    .o_mem_address (o_mem_address),
    .o_mem_wdata   (o_mem_wdata),
    .i_mem_ready   (i_mem_ready),
    .i_mem_rvalid  (i_mem_rvalid),
    .i_mem_rdata   (i_mem_rdata)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int vecs = 0;
  int errs = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference state: memory as the initiators see it, and memory as the controller holds it.
  logic [31:0] ref_mem [logic [23:0]];
  logic [31:0] sram    [logic [23:0]];
  logic [55:0] wq[$];
  logic [23:0] raddr_q[$];
  logic [31:0] exp_q[$];
  bit          cmd_log[$];
  int          ready_mode = 1;
  bit          rv_rand = 1'b0;
  int          rv_delay = 0;
  bit          rd_pending = 1'b0, rd_stale = 1'b0;
  int          rd_wait = 0;
  logic [31:0] rd_val = '0;
  bit          last_acc = 1'b0;

  function automatic logic [31:0] dflt(input logic [23:0] a);
    return {8'h5A, a};
  endfunction

  task automatic tick();
    bit          exp_ack, was_reset, q_empty;
    logic [55:0] w_exp;
    logic [23:0] r_exp;
    logic [31:0] d_exp;
    i_mem_rvalid = 1'b0;
    i_mem_rdata  = $urandom();
    if (rd_pending) begin
      if (rd_wait == 0) begin
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = rd_val;
        rd_pending   = 1'b0;
      end else rd_wait--;
    end
    case (ready_mode)
      0:       i_mem_ready = 1'b0;
      1:       i_mem_ready = 1'b1;
      default: i_mem_ready = 1'($urandom_range(0, 1));
    endcase
    #1;
    was_reset = i_reset;
    last_acc  = i_request && !o_busy && (i_bank == BANK) && !i_reset;
    exp_ack   = i_mem_rvalid && !rd_stale && !i_reset;
    if (i_mem_rvalid) rd_stale = 1'b0;
    if (!i_reset) begin
      if (last_acc && i_write) begin
        wq.push_back({i_address, i_data});
        ref_mem[i_address] = i_data;
      end
      if (last_acc && !i_write) begin
        exp_q.push_back(ref_mem.exists(i_address) ? ref_mem[i_address] : dflt(i_address));
        raddr_q.push_back(i_address);
      end
      if (o_mem_req && i_mem_ready) begin
        cmd_log.push_back(o_mem_write);
        if (o_mem_write) begin
          if (wq.size() == 0) check("extra_write", 64'(o_mem_address), 64'hFFFF_FFFF_FFFF_FFFF);
          else begin
            w_exp = wq.pop_front();
            check("write_cmd", 64'({o_mem_address, o_mem_wdata}), 64'(w_exp));
          end
          sram[o_mem_address] = o_mem_wdata;
        end else begin
          q_empty = (raddr_q.size() == 0);
          r_exp   = q_empty ? 24'h0 : raddr_q.pop_front();
          check("read_cmd", 64'({wq.size() != 0, q_empty, o_mem_address}), 64'({2'b00, r_exp}));
          rd_pending = 1'b1;
          rd_wait    = rv_rand ? int'($urandom_range(0, 3)) : rv_delay;
          rd_val     = sram.exists(o_mem_address) ? sram[o_mem_address] : dflt(o_mem_address);
        end
      end
    end
    @(posedge i_clk);
    #1;
    if (was_reset) begin
      wq.delete();
      raddr_q.delete();
      exp_q.delete();
      cmd_log.delete();
      ref_mem = sram;
      if (rd_pending) rd_stale = 1'b1;
    end
    if (exp_ack) begin
      q_empty = (exp_q.size() == 0);
      d_exp   = q_empty ? 32'h0 : exp_q.pop_front();
      check("ack", 64'({q_empty, o_ack, o_data}), 64'({1'b0, 1'b1, d_exp}));
    end else begin
      check("no_ack", 64'(o_ack), 64'd0);
    end
  endtask

  task automatic bus_op(input bit wr, input logic [23:0] a, input logic [31:0] d);
    int n;
    n = 0;
    i_request = 1'b1;
    i_write   = wr;
    i_bank    = BANK;
    i_address = a;
    i_data    = d;
    do begin
      tick();
      n++;
    end while (!last_acc && n < 200);
    if (!last_acc) check("accept_timeout", 64'd0, 64'd1);
    i_request = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    ready_mode = 1;
    while ((exp_q.size() != 0 || wq.size() != 0 || rd_pending) && n < 300) begin
      tick();
      n++;
    end
    check("drain", 64'(exp_q.size() + wq.size() + int'(rd_pending)), 64'd0);
  endtask

  typedef struct packed {
    logic        req, wr;
    logic [3:0]  bank;
    logic [23:0] addr;
    logic [31:0] data;
    logic        rdy, rv;
    logic [31:0] rdata;
    logic        e_busy, e_req, e_wr;
    logic [23:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_ack;
    logic [31:0] e_odata;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int          n;
    logic [7:0]  ord;
    logic [31:0] d4;

    tbl[0] = '{1, 1, BANK, 24'h000123, 32'hDEADBEEF, 1, 0, 32'h0,
               0, 1, 1, 24'h000123, 32'hDEADBEEF, 0, 32'h0};
    tbl[1] = '{0, 0, BANK, 24'h0, 32'h0, 1, 0, 32'h0,
               0, 0, 0, 24'h0, 32'h0, 0, 32'h0};
    tbl[2] = '{1, 0, BANK, 24'h000010, 32'h0, 1, 0, 32'h0,
               1, 1, 0, 24'h000010, 32'h0, 0, 32'h0};
    tbl[3] = '{0, 0, BANK, 24'h0, 32'h0, 1, 0, 32'h0,
               1, 0, 0, 24'h0, 32'h0, 0, 32'h0};
    tbl[4] = '{0, 0, BANK, 24'h0, 32'h0, 0, 1, 32'hCAFEF00D,
               0, 0, 0, 24'h0, 32'h0, 1, 32'hCAFEF00D};
    tbl[5] = '{1, 1, 4'd2, 24'h000005, 32'h1, 1, 0, 32'h0,
               0, 0, 0, 24'h0, 32'h0, 0, 32'hCAFEF00D};
    tbl[6] = '{1, 0, 4'd2, 24'h000007, 32'h0, 1, 0, 32'h0,
               0, 0, 0, 24'h0, 32'h0, 0, 32'hCAFEF00D};
    tbl[7] = '{0, 0, BANK, 24'h0, 32'h0, 1, 1, 32'h12345678,
               0, 0, 0, 24'h0, 32'h0, 0, 32'hCAFEF00D};

    i_reset = 1'b1; i_request = 1'b0; i_write = 1'b0; i_bank = '0; i_address = '0;
    i_data = '0; i_mem_ready = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = '0;
    repeat (2) @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    check("reset_ctl", 64'({o_busy, o_ack, o_mem_req, o_mem_write, o_mem_address}), 64'd0);
    check("reset_data", {o_data, o_mem_wdata}, 64'd0);

    // Single write, single read (ack at accept+3), bank mismatch, stray rvalid.
    foreach (tbl[i]) begin
      i_request = tbl[i].req;  i_write = tbl[i].wr;  i_bank = tbl[i].bank;
      i_address = tbl[i].addr; i_data = tbl[i].data; i_mem_ready = tbl[i].rdy;
      i_mem_rvalid = tbl[i].rv; i_mem_rdata = tbl[i].rdata;
      @(posedge i_clk);
      #1;
      check($sformatf("tbl%0d_ctl", i), 64'({o_busy, o_mem_req, o_mem_write, o_ack}),
            64'({tbl[i].e_busy, tbl[i].e_req, tbl[i].e_wr, tbl[i].e_ack}));
      check($sformatf("tbl%0d_cmd", i), 64'({o_mem_address, o_mem_wdata}),
            64'({tbl[i].e_addr, tbl[i].e_wdata}));
      check($sformatf("tbl%0d_data", i), 64'(o_data), 64'(tbl[i].e_odata));
    end
    i_request = 1'b0;

    // Four posted writes fill the buffer; a read of the same word must see the last one.
    ready_mode = 0;
    cmd_log.delete();
    d4 = 32'h4444_0004;
    bus_op(1, 24'h40, 32'h4444_0001);
    bus_op(1, 24'h40, 32'h4444_0002);
    bus_op(1, 24'h40, 32'h4444_0003);
    bus_op(1, 24'h40, d4);
    check("busy_full", 64'(o_busy), 64'd1);
    i_request = 1'b1; i_write = 1'b0; i_bank = BANK; i_address = 24'h40;
    repeat (10) tick();
    check("busy_hold", 64'({o_busy, o_mem_req, last_acc}), 64'b110);
    ready_mode = 1;
    bus_op(0, 24'h40, 32'h0);
    drain();
    ord = '0;
    foreach (cmd_log[i]) ord = {ord[6:0], cmd_log[i]};
    check("cmd_order", 64'({8'(cmd_log.size()), ord}), 64'({8'd5, 8'b0001_1110}));
    check("raw_data", 64'(o_data), 64'(d4));

    // Push and pop on the same edge at count 2.
    ready_mode = 0;
    bus_op(1, 24'h50, 32'h5000_0000);
    bus_op(1, 24'h51, 32'h5100_0000);
    ready_mode = 1;
    bus_op(1, 24'h52, 32'h5200_0000);
    check("cnt_pushpop", 64'(dut.wbuf_count), 64'd2);
    drain();

    // Reset while waiting for read data; the late rvalid must not produce an ack.
    rv_delay = 1;
    bus_op(0, 24'h60, 32'h0);
    tick();
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    check("rst_wait_ctl", 64'({o_busy, o_ack, o_mem_req, o_mem_write, o_mem_address}), 64'd0);
    check("rst_wait_data", {o_data, o_mem_wdata}, 64'd0);
    tick();
    check("rst_late_rvalid", 64'({o_ack, o_busy}), 64'd0);

    // Reset with buffered writes: they are discarded and never reach memory.
    ready_mode = 0;
    bus_op(1, 24'h70, 32'h7000_0001);
    bus_op(1, 24'h71, 32'h7000_0002);
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    ready_mode = 1;
    n = 0;
    repeat (5) begin
      tick();
      if (o_mem_req) n++;
    end
    check("rst_no_cmd", 64'(n), 64'd0);

    // Random traffic against the memory model.
    ready_mode = 2;
    rv_rand = 1'b1;
    for (int k = 0; k < 250; k++) begin
      repeat ($urandom_range(0, 2)) tick();
      if ($urandom_range(0, 7) == 0) begin
        i_request = 1'b1;
        i_write   = 1'($urandom_range(0, 1));
        i_bank    = BANK + 4'($urandom_range(1, 15));
        i_address = 24'($urandom_range(0, 7));
        i_data    = $urandom();
        tick();
        i_request = 1'b0;
      end else begin
        bus_op(1'($urandom_range(0, 1)), 24'($urandom_range(0, 7)), $urandom());
      end
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
